univ_shift_reg: RTL and testbench

- Parametrised N-bit universal register, the next generation of the single-bit D flip-flop with asynchronous set and reset.
- Supports hold, shift right, shift left and parallel load, plus a synchronous set.
- Includes a saturating shift counter that flags when every loaded bit has been shifted out.
- Used as a serialiser/deserialiser and as a general state register in datapath blocks.

---
 rtl/usr_pkg.sv | 9 +
 rtl/usr_shift_cnt.sv | 32 +++
 rtl/univ_shift_reg.sv | 92 +++++++++
 tb/tb_univ_shift_reg.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings.
package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/usr_shift_cnt.sv
// Saturating shift counter: clears on load/set, counts shifts up to WIDTH,
// and flags empty once every loaded bit has been shifted out.
module usr_shift_cnt #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             empty
);

  logic sat;

  // Saturation decode doubles as the empty flag.
  assign sat   = (cnt == CNT_W'(WIDTH));
  assign empty = sat;

  // Counter register; clear wins over increment, increment stops at WIDTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal N-bit register: hold, shift right/left, parallel load and
// synchronous active-low set, with a saturating shift counter.
// Optional rotate mode enabled by defining UNIV_SHIFT_REG_ROTATE_EN.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int unsigned      CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             set,
  input  logic [1:0]       mode,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
  input  logic             rot,
`endif
  input  logic             sil,
  input  logic             sir,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sor,
  output logic             sol,
  output logic [CNT_W-1:0] cnt,
  output logic             empty
);

  logic [WIDTH-1:0] q_nxt;
  logic             shr_in;
  logic             shl_in;
  logic             is_shift;
  logic             cnt_clear;
  logic             cnt_inc;

  // Fill bits for the vacated end; rotation feeds back the opposite end.
`ifdef UNIV_SHIFT_REG_ROTATE_EN
  assign shr_in = rot ? q[0]       : sil;
  assign shl_in = rot ? q[WIDTH-1] : sir;
`else
  assign shr_in = sil;
  assign shl_in = sir;
`endif

  assign is_shift  = (mode == MODE_SHR) || (mode == MODE_SHL);
  assign cnt_clear = en && (!set || (mode == MODE_LOAD));
  assign cnt_inc   = en && set && is_shift;

  // Next-state decode: enable masks everything, then set, then mode.
  always_comb begin
    q_nxt = q;
    if (en) begin
      if (!set) begin
        q_nxt = '1;
      end else begin
        case (mode)
          MODE_SHR:  q_nxt = {shr_in, q[WIDTH-1:1]};
          MODE_SHL:  q_nxt = {q[WIDTH-2:0], shl_in};
          MODE_LOAD: q_nxt = d;
          default:   q_nxt = q;
        endcase
      end
    end
  end

  // Data register with asynchronous reset to RESET_VAL.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_VAL;
    end else begin
      q <= q_nxt;
    end
  end

  assign qbar = ~q;
  assign sor  = q[0];
  assign sol  = q[WIDTH-1];

  usr_shift_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .cnt   (cnt),
    .empty (empty)
  );

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8): directed vector table,
// hand-written reset/rotate sequences, and randomized model comparison.
module tb_univ_shift_reg;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          en;
  logic          set;
  logic [1:0]    mode;
  logic          rot;
  logic          sil;
  logic          sir;
  logic [W-1:0]  d;
  logic [W-1:0]  q;
  logic [W-1:0]  qbar;
  logic          sor;
  logic          sol;
  logic [CW-1:0] cnt;
  logic          empty;

  int n_cmp;
  int n_bad;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .set   (set),
    .mode  (mode),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    .rot   (rot),
`endif
    .sil   (sil),
    .sir   (sir),
    .d     (d),
    .q     (q),
    .qbar  (qbar),
    .sor   (sor),
    .sol   (sol),
    .cnt   (cnt),
    .empty (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       set;
    logic [1:0] mode;
    logic       sil;
    logic       sir;
    logic [7:0] d;
    logic [7:0] exp_q;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: plain integers.
  int m_q;
  int m_cnt;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compares every output against an expected register value and count.
  task automatic check_all(input string tag, input int eq, input int ec);
    check({tag, " q"},     int'(q), eq);
    check({tag, " cnt"},   int'(cnt), ec);
    check({tag, " qbar"},  int'(qbar), (~eq) & 8'hFF);
    check({tag, " sor"},   int'(sor), eq % 2);
    check({tag, " sol"},   int'(sol), (eq / 128) % 2);
    check({tag, " empty"}, int'(empty), (ec == 8) ? 1 : 0);
  endtask

  // Behavioural model of one active clock edge.
  task automatic model_edge();
    int fill;
    if (!en) return;
    if (!set) begin
      m_q = 255; m_cnt = 0;
      return;
    end
    case (mode)
      2'd1: begin
        fill  = (ROT_EN && rot) ? (m_q % 2) : int'(sil);
        m_q   = (m_q / 2) + fill * 128;
        m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
      end
      2'd2: begin
        fill  = (ROT_EN && rot) ? (m_q / 128) : int'(sir);
        m_q   = ((m_q * 2) % 256) + fill;
        m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
      end
      2'd3: begin
        m_q = int'(d); m_cnt = 0;
      end
      default: ;
    endcase
  endtask

  task automatic drive(input logic e, input logic s, input logic [1:0] m,
                       input logic l, input logic r, input logic [7:0] dd);
    en = e; set = s; mode = m; sil = l; sir = r; d = dd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic e, input logic s, input logic [1:0] m,
                     input logic l, input logic r, input logic [7:0] dd,
                     input logic [7:0] eq, input int ec);
    vec_t v;
    v.en = e; v.set = s; v.mode = m; v.sil = l; v.sir = r; v.d = dd;
    v.exp_q = eq; v.exp_cnt = ec;
    vecs.push_back(v);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rot = 1'b0;
    reset = 1'b0;
    drive(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00);

    // Vector table: load/shift-right saturation, shift left, priority, hold.
    add(1, 1, 2'd3, 0, 0, 8'hA5, 8'hA5, 0);
    add(1, 1, 2'd1, 1, 0, 8'h00, 8'hD2, 1);
    add(1, 1, 2'd1, 1, 0, 8'h00, 8'hE9, 2);
    add(1, 1, 2'd1, 1, 0, 8'h00, 8'hF4, 3);
    add(1, 1, 2'd1, 1, 0, 8'h00, 8'hFA, 4);
    add(1, 1, 2'd1, 1, 0, 8'h00, 8'hFD, 5);
    add(1, 1, 2'd1, 1, 0, 8'h00, 8'hFE, 6);
    add(1, 1, 2'd1, 1, 0, 8'h00, 8'hFF, 7);
    add(1, 1, 2'd1, 1, 0, 8'h00, 8'hFF, 8);
    add(1, 1, 2'd1, 1, 0, 8'h00, 8'hFF, 8);
    add(1, 1, 2'd2, 0, 0, 8'h00, 8'hFE, 8);
    add(1, 1, 2'd3, 0, 0, 8'h81, 8'h81, 0);
    add(1, 1, 2'd2, 0, 0, 8'h00, 8'h02, 1);
    add(1, 0, 2'd3, 0, 0, 8'h00, 8'hFF, 0);
    add(0, 0, 2'd3, 0, 0, 8'h00, 8'hFF, 0);
    add(1, 1, 2'd2, 0, 0, 8'h00, 8'hFE, 1);
    for (int i = 0; i < 5; i++) add(1, 1, 2'd0, 1, 1, 8'h3C, 8'hFE, 1);
    for (int i = 0; i < 5; i++) add(0, 1, 2'd1, 0, 1, 8'h3C, 8'hFE, 1);

    // Reset state.
    #12;
    check_all("reset", 8'h00, 0);
    reset = 1'b1;
    #3;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].set, vecs[i].mode, vecs[i].sil, vecs[i].sir, vecs[i].d);
      if (i == 12) check("sol before shl", int'(sol), 1);
      if (i >= 1 && i <= 8) check($sformatf("sor seq %0d", i), int'(sor), (8'hA5 >> (i - 1)) & 1);
      tick();
      check_all($sformatf("vec%0d", i), int'(vecs[i].exp_q), vecs[i].exp_cnt);
    end

    // Asynchronous reset between edges, mid-shift.
    drive(1, 1, 2'd3, 0, 0, 8'hA5);
    tick();
    drive(1, 1, 2'd1, 1, 0, 8'h00);
    tick();
    check_all("pre-reset", 8'hD2, 1);
    #2 reset = 1'b0;
    #1;
    check_all("async reset", 8'h00, 0);
    #2 reset = 1'b1;
    #1;
    check_all("post reset hold", 8'h00, 0);

`ifdef UNIV_SHIFT_REG_ROTATE_EN
    // Rotate: load 81, rotate left once with sir=0, then rotate right twice.
    drive(1, 1, 2'd3, 0, 0, 8'h81);
    tick();
    rot = 1'b1;
    drive(1, 1, 2'd2, 0, 0, 8'h00);
    tick();
    check_all("rotl", 8'h03, 1);
    drive(1, 1, 2'd1, 0, 0, 8'h00);
    tick();
    tick();
    check_all("rotr2", 8'hC0, 3);
    rot = 1'b0;
`endif

    // Randomized comparison against the model, with occasional async reset.
    drive(1, 0, 2'd0, 0, 0, 8'h00);
    tick();
    m_q = 255; m_cnt = 0;
    check_all("rand start", m_q, m_cnt);
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 7) != 0);
      set  = ($urandom_range(0, 15) != 0);
      mode = 2'($urandom_range(0, 3));
      if (i % 40 < 25 && mode == 2'd3) mode = 2'd1;
      sil  = 1'($urandom);
      sir  = 1'($urandom);
      d    = 8'($urandom);
      rot  = ROT_EN ? 1'($urandom) : 1'b0;
      if ($urandom_range(0, 49) == 0) begin
        #2 reset = 1'b0;
        #1;
        m_q = 0; m_cnt = 0;
        check_all("rand reset", m_q, m_cnt);
        #1 reset = 1'b1;
      end
      tick();
      model_edge();
      check_all($sformatf("rand%0d", i), m_q, m_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
